// File: rtl/mdu_if.sv
// mdu_if: bundles the multiply/divide unit's operation, operand and result
// signals.
//   MDUOP  [3:0]  operation code (driven by the pipeline)
//   Start         qualifies a MULT/MULTU/DIV/DIVU for one cycle
//   SrcA  [31:0]  operand A / MTHI / MTLO data
//   SrcB  [31:0]  operand B
//   Busy          operation in flight (driven by the MDU)
//   MDUOut[31:0]  HI/LO read data for MFHI/MFLO (driven by the MDU)
interface mdu_if;
    logic [3:0]  MDUOP;
    logic        Start;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] MDUOut;

    modport master (output MDUOP, Start, SrcA, SrcB, input Busy, MDUOut);
    modport slave  (input MDUOP, Start, SrcA, SrcB, output Busy, MDUOut);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
// The MDU latches its operands on Start and raises Busy for a fixed number
// of cycles. HI/LO are written on the final busy edge. MTHI/MTLO write
// directly when the MDU is idle. MFHI/MFLO read HI/LO combinationally.
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mdu_if slave port (MDUOP, Start, SrcA, SrcB, Busy, MDUOut)
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic [63:0]      res_s;
    logic             res_wr_s;
    logic             start_ok_s;
    logic [CNT_W-1:0] load_s;
    logic [31:0]      mdu_out_s;

    // 64-bit product; signed mode sign-extends both operands first, so the
    // low 64 bits of the wide product are the correct two's-complement result.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        if (sgn) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end else begin
            ea = {32'h0000_0000, a};
            eb = {32'h0000_0000, b};
        end
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed mode divides magnitudes and then
    // restores signs: quotient truncates toward zero, remainder follows the
    // dividend. 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ma = neg_a ? (32'd0 - a) : a;
        mb = neg_b ? (32'd0 - b) : b;
        // A zero divisor never commits a result; substitute 1 to keep the
        // arithmetic well defined.
        if (mb == 32'd0) begin
            mb = 32'd1;
        end else begin
            mb = mb;
        end
        q = ma / mb;
        r = ma % mb;
        if (neg_a ^ neg_b) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (neg_a) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    // Decode whether Start launches a long op, and the busy count to load.
    always_comb begin
        start_ok_s = 1'b0;
        load_s     = '0;
        case (bus.MDUOP)
            OP_MULT, OP_MULTU: begin
                start_ok_s = bus.Start;
                load_s     = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                start_ok_s = bus.Start;
                load_s     = CNT_W'(DIV_CYCLES);
            end
            default: begin
                start_ok_s = 1'b0;
                load_s     = '0;
            end
        endcase
    end

    // Result of the captured operation, committed on the last busy edge.
    always_comb begin
        res_s    = 64'd0;
        res_wr_s = 1'b0;
        case (op_r)
            OP_MULT: begin
                res_s    = mul64(a_r, b_r, 1'b1);
                res_wr_s = 1'b1;
            end
            OP_MULTU: begin
                res_s    = mul64(a_r, b_r, 1'b0);
                res_wr_s = 1'b1;
            end
            OP_DIV: begin
                res_s    = div64(a_r, b_r, 1'b1);
                res_wr_s = (b_r != 32'd0);
            end
            OP_DIVU: begin
                res_s    = div64(a_r, b_r, 1'b0);
                res_wr_s = (b_r != 32'd0);
            end
            default: begin
                res_s    = 64'd0;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // Sequencer: launch, count down, commit HI/LO, and service MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            op_r    <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_r <= ST_RUN;
                        cnt_r   <= load_s;
                        op_r    <= bus.MDUOP;
                        a_r     <= bus.SrcA;
                        b_r     <= bus.SrcB;
                    end else if (bus.MDUOP == OP_MTHI) begin
                        hi_r <= bus.SrcA;
                    end else if (bus.MDUOP == OP_MTLO) begin
                        lo_r <= bus.SrcA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        if (res_wr_s) begin
                            hi_r <= res_s[63:32];
                            lo_r <= res_s[31:0];
                        end else begin
                            hi_r <= hi_r;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // HI/LO read mux; independent of Busy.
    always_comb begin
        mdu_out_s = 32'd0;
        case (bus.MDUOP)
            OP_MFHI: mdu_out_s = hi_r;
            OP_MFLO: mdu_out_s = lo_r;
            default: mdu_out_s = 32'd0;
        endcase
    end

    assign bus.Busy   = (state_r == ST_RUN);
    assign bus.MDUOut = mdu_out_s;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. Each stimulus cycle pushes its expected
// Busy / MDUOut values; a negedge monitor pops and compares them.
module tb_mdu;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef struct {
        string       nm;
        int          eb;   // -1: don't check Busy
        bit          co;   // check MDUOut
        logic [31:0] eo;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.eb >= 0) begin
                checks++;
                if (bus.Busy !== mon_e.eb[0]) begin
                    failures++;
                    $display("FAIL %s busy: got %0b expected %0d", mon_e.nm, bus.Busy, mon_e.eb);
                end
            end
            if (mon_e.co) begin
                checks++;
                if (bus.MDUOut !== mon_e.eo) begin
                    failures++;
                    $display("FAIL %s out: got %08h expected %08h", mon_e.nm, bus.MDUOut, mon_e.eo);
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] op, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic rs, input int eb,
                       input bit co, input logic [31:0] eo, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rs;
        bus.MDUOP = op;
        bus.Start = st;
        bus.SrcA  = a;
        bus.SrcB  = b;
        e.nm = nm;
        e.eb = eb;
        e.co = co;
        e.eo = eo;
        exp_q.push_back(e);
    endtask

    // Busy cycles with scrambled operands: results must not depend on them.
    task automatic busy_run(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc(OP_NONE, 1'b0, $urandom, $urandom, 1'b0, 1, 1'b0, 32'd0, nm);
        end
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input string nm);
        cyc(op, 1'b1, a, b, 1'b0, 0, 1'b0, 32'd0, nm);
        busy_run(n, nm);
    endtask

    task automatic rd(input logic [31:0] hi, input logic [31:0] lo, input string nm);
        cyc(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1, hi, {nm, "_hi"});
        cyc(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1, lo, {nm, "_lo"});
    endtask

    initial begin
        bus.MDUOP = OP_NONE;
        bus.Start = 1'b0;
        bus.SrcA  = 32'd0;
        bus.SrcB  = 32'd0;

        // reset state
        cyc(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b1, 0, 1'b1, 32'd0, "rst_hi");
        cyc(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b1, 0, 1'b1, 32'd0, "rst_lo");
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1, 32'd0, "rst_rel");

        launch(OP_MULT, 32'hFFFF_FFFF, 32'd2, 5, "mult");
        rd(32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");

        launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, "multu");
        rd(32'h0000_0001, 32'hFFFF_FFFE, "multu");

        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div_m7_2");
        rd(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");

        launch(OP_DIVU, 32'd7, 32'd2, 10, "divu_7_2");
        rd(32'd1, 32'd3, "divu_7_2");

        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
        rd(32'd0, 32'h8000_0000, "div_ovf");

        launch(OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, "div_7_m2");
        rd(32'd1, 32'hFFFF_FFFD, "div_7_m2");

        // MTHI, then divide by zero leaves HI/LO alone
        cyc(OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0, 32'd0, "mthi");
        launch(OP_DIVU, 32'd99, 32'd0, 10, "divu_z");
        rd(32'h1234_5678, 32'hFFFF_FFFD, "divu_z");

        // MULT with Start+DIV and MTLO while busy; MFLO during busy shows old LO
        cyc(OP_MULT, 1'b1, 32'd3, 32'd4, 1'b0, 0, 1'b0, 32'd0, "ovl_start");
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1, 1'b0, 32'd0, "ovl_b1");
        cyc(OP_DIV, 1'b1, 32'd100, 32'd3, 1'b0, 1, 1'b0, 32'd0, "ovl_b2");
        cyc(OP_MTLO, 1'b0, 32'h0000_AAAA, 32'd0, 1'b0, 1, 1'b0, 32'd0, "ovl_b3");
        cyc(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b0, 1, 1'b1, 32'hFFFF_FFFD, "ovl_b4");
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1, 1'b1, 32'd0, "ovl_b5");
        rd(32'd0, 32'd12, "ovl");

        // Start with non-long ops is ignored; MTLO while idle writes LO
        cyc(OP_NONE, 1'b1, 32'd5, 32'd5, 1'b0, 0, 1'b0, 32'd0, "st_none");
        cyc(4'd9, 1'b1, 32'd5, 32'd5, 1'b0, 0, 1'b0, 32'd0, "st_op9");
        cyc(OP_MTLO, 1'b1, 32'h0000_0055, 32'd0, 1'b0, 0, 1'b0, 32'd0, "mtlo_st");
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1, 32'd0, "ign_chk");
        rd(32'd0, 32'h0000_0055, "ign");

        // reset mid-DIV aborts it
        cyc(OP_MTHI, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 1'b0, 32'd0, "pre_rst");
        launch(OP_DIV, 32'd100, 32'd7, 2, "rst_div");
        cyc(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b1, 0, 1'b1, 32'd0, "rst_mid_hi");
        cyc(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1, 32'd0, "rst_mid_lo");
        for (int i = 0; i < 10; i++) begin
            cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b0, 32'd0, "rst_idle");
        end
        rd(32'd0, 32'd0, "rst_nowr");

        launch(OP_MULTU, 32'd6, 32'd7, 5, "post_rst");
        rd(32'd0, 32'd42, "post_rst");

        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, -1, 1'b0, 32'd0, "tail");
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy duration of MULT/MULTU, in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: Busy duration of DIV/DIVU, in cycles.
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MDUOP  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-007 Start  input  1  qualifies MULT/MULTU/DIV/DIVU for exactly one EX cycle.
REQ-008 SrcA  input  32  operand A (dividend / multiplicand / MTHI/MTLO data).
REQ-009 SrcB  input  32  operand B (divisor / multiplier).
REQ-010 Busy  output  1  registered; high while an operation is in flight.
REQ-011 MDUOut  output  32  combinational read data for MFHI/MFLO.

Function
REQ-012 The block SHALL hold two 32-bit registers, HI and LO, plus a down-counter and captured operands/op.
REQ-013 States: IDLE (counter=0, Busy=0) and RUN (counter>0, Busy=1).
REQ-014 IDLE->RUN on a rising edge where Start=1, Busy=0 and MDUOP is 1-4: capture SrcA, SrcB, MDUOP; load the counter with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
REQ-015 Busy SHALL be high for exactly the loaded count of cycles, starting the cycle after the Start edge.
REQ-016 RUN: the counter SHALL decrement each edge; on the edge where it reaches 0, HI/LO SHALL be written and the state SHALL return to IDLE.
REQ-017 New HI/LO values SHALL be visible on MDUOut in the first cycle Busy=0.
REQ-018 Start=1 with MDUOP not 1-4 SHALL be ignored.
REQ-019 Start=1 while Busy=1 SHALL be ignored; the in-flight operation continues unaffected.
REQ-020 MULT SHALL write the signed 64-bit product of the captured operands: {HI,LO} = product.
REQ-021 MULTU SHALL write the unsigned 64-bit product: {HI,LO} = product.
REQ-022 DIV SHALL write the signed quotient to LO, truncated toward zero, and the remainder to HI; the remainder takes the sign of the dividend.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-024 DIVU SHALL write the unsigned quotient to LO and the remainder to HI.
REQ-025 DIV/DIVU with divisor 0 SHALL still run DIV_CYCLES with Busy high, then leave HI and LO unchanged.
REQ-026 MTHI/MTLO with Busy=0 SHALL write SrcA into HI/LO at the clock edge; Start is not required.
REQ-027 MTHI/MTLO with Busy=1 SHALL be ignored.
REQ-028 MDUOut SHALL be HI when MDUOP=MFHI, LO when MDUOP=MFLO, and 0 otherwise, regardless of Busy.
REQ-029 Upstream stall logic SHALL stall any MDU instruction while (Busy | Start); the block does not itself guard against reading stale HI/LO.
REQ-030 SrcA/SrcB changes after the Start edge SHALL NOT affect the result.

Reset
REQ-031 Asserting reset SHALL immediately set HI=0, LO=0, counter=0 and Busy=0, and clear the captured operands and op.
REQ-032 Reset asserted mid-operation SHALL abort it, with no later HI/LO write.
REQ-033 After reset deasserts, the block SHALL be in IDLE and accept Start on the next edge.

Verification
REQ-034 MULT with SrcA=0xFFFFFFFF, SrcB=2 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE (via MFHI/MFLO).
REQ-035 MULTU with SrcA=0xFFFFFFFF, SrcB=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 DIV with SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
REQ-037 MTHI 0x12345678, then DIVU with SrcB=0 -> Busy high 10 cycles; HI still 0x12345678, LO unchanged.
REQ-038 MULT started, then Start+DIV at busy cycle 2 and MTLO 0xAAAA at cycle 3 -> both ignored; Busy falls after 5 cycles with the MULT result only.
REQ-039 DIV started, reset pulsed at busy cycle 3 -> Busy=0 and HI=LO=0 immediately; no write when the original 10 cycles would have elapsed.
